// File: rtl/stoch_matvec_sched_if.sv
// rtl/stoch_matvec_sched_if.sv - row result valid/ready port of the stochastic mat-vec scheduler
// The scheduler drives the master side; the result consumer uses the slave side.
interface stoch_matvec_sched_if #(
  parameter int ROW_W = 2,
  parameter int CNT_W = 9
);
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_data;
  logic [ROW_W-1:0] res_row;
  logic             res_last;

  modport master (output res_valid, output res_data, output res_row, output res_last, input res_ready);
  modport slave  (input res_valid, input res_data, input res_row, input res_last, output res_ready);
endinterface

// File: rtl/stoch_matvec_sched.sv
// rtl/stoch_matvec_sched.sv - sequences a shared stochastic dot-product unit over NUM_ROWS rows
// Optional settle phase per row enabled by defining STOCH_SCHED_WARMUP_EN.
module stoch_matvec_sched #(
  parameter int NUM_ROWS = 4,
  parameter int WINDOW   = 256,
  parameter int WARMUP   = 4,
  localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CNT_W   = $clog2(WINDOW + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [ROW_W-1:0] row_sel,
  output logic             dp_nrst,
  output logic             dp_en,
  input  logic             y,
  stoch_matvec_sched_if.master res
);

`ifdef STOCH_SCHED_WARMUP_EN
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, OUT} state_t;
  logic [WARM_W-1:0] warm_q, warm_d;
`else
  localparam int unused_warmup = WARMUP;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, OUT} state_t;
`endif

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic [ROW_W-1:0] rrow_q, rrow_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             nrst_q, nrst_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ones_d  = ones_q;
    win_d   = win_q;
    valid_d = valid_q;
    data_d  = data_q;
    rrow_d  = rrow_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef STOCH_SCHED_WARMUP_EN
    warm_d  = warm_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          row_d   = '0;
        end
      end
      CLEAR: begin
        ones_d = '0;
        win_d  = '0;
`ifdef STOCH_SCHED_WARMUP_EN
        warm_d  = '0;
        state_d = WARM;
`else
        state_d = RUN;
`endif
      end
`ifdef STOCH_SCHED_WARMUP_EN
      WARM: begin
        warm_d = warm_q + WARM_W'(1);
        if (warm_q == WARM_W'(WARMUP - 1)) state_d = RUN;
      end
`endif
      RUN: begin
        ones_d = ones_q + CNT_W'(y);
        win_d  = win_q + CNT_W'(1);
        if (win_q == CNT_W'(WINDOW - 1)) begin
          data_d  = ones_q + CNT_W'(y);
          rrow_d  = row_q;
          last_d  = (row_q == ROW_W'(NUM_ROWS - 1));
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (valid_q && res.res_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = CLEAR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so the unit is held cleared while nRST is low as well as in CLEAR.
    nrst_d = (state_d != CLEAR);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      row_q   <= '0;
      ones_q  <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      rrow_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      nrst_q  <= 1'b0;
`ifdef STOCH_SCHED_WARMUP_EN
      warm_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      ones_q  <= ones_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      rrow_q  <= rrow_d;
      last_q  <= last_d;
      done_q  <= done_d;
      nrst_q  <= nrst_d;
`ifdef STOCH_SCHED_WARMUP_EN
      warm_q  <= warm_d;
`endif
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign row_sel       = row_q;
  assign dp_nrst       = nrst_q;
  assign dp_en         = (state_q == RUN);
  assign res.res_valid = valid_q;
  assign res.res_data  = data_q;
  assign res.res_row   = rrow_q;
  assign res.res_last  = last_q;

endmodule

// File: tb/tb_stoch_matvec_sched.sv
// tb/tb_stoch_matvec_sched.sv - randomized self-checking bench for stoch_matvec_sched
// Expected timing and counts come from a cycle-budget model of each row.
module tb_stoch_matvec_sched;
  localparam int NR    = 4;
  localparam int W     = 16;
`ifdef STOCH_SCHED_WARMUP_EN
  localparam int WU    = 4;
`else
  localparam int WU    = 0;
`endif
  localparam int ROW_W = (NR > 1) ? $clog2(NR) : 1;
  localparam int CNT_W = $clog2(W + 1);

  logic             CLK = 1'b0;
  logic             nRST;
  logic             start;
  logic             busy;
  logic             done;
  logic [ROW_W-1:0] row_sel;
  logic             dp_nrst;
  logic             dp_en;
  logic             y;

  stoch_matvec_sched_if #(.ROW_W(ROW_W), .CNT_W(CNT_W)) res_if ();

  stoch_matvec_sched #(.NUM_ROWS(NR), .WINDOW(W), .WARMUP(4)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .busy(busy), .done(done),
    .row_sel(row_sel), .dp_nrst(dp_nrst), .dp_en(dp_en), .y(y), .res(res_if.master)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit pattern(input int mode, input int k);
    case (mode)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return (k % 2) == 0;
      4:       return 1'b0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One full pass; when launch=0 the pass is already in CLEAR of row 0.
  task automatic run_pass(input int mode, input int stall_max, input bit launch,
                          input bit chain, input bit poke);
    int cyc;
    int ones;
    int stall;
    bit b;
    cyc = 1;
    if (launch) begin
      check("idle_busy", busy, 0);
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int r = 0; r < NR; r++) begin
      check("clr_nrst", dp_nrst, 0);
      check("clr_row", row_sel, r);
      check("clr_busy", busy, 1);
      check("clr_en", dp_en, 0);
      check("clr_valid", res_if.res_valid, 0);
      y = 1'($urandom_range(0, 1));
      step(); cyc++;
      for (int k = 0; k < WU; k++) begin
        y = (mode == 4) ? 1'b1 : 1'($urandom_range(0, 1));
        check("warm_nrst", dp_nrst, 1);
        check("warm_en", dp_en, 0);
        step(); cyc++;
      end
      ones = 0;
      for (int k = 0; k < W; k++) begin
        b = pattern(mode, k);
        y = b;
        ones += int'(b);
        if (poke && r == 1 && k == W / 2) start = 1'b1;
        check("run_en", dp_en, 1);
        check("run_nrst", dp_nrst, 1);
        step(); cyc++;
        start = 1'b0;
      end
      y = 1'($urandom_range(0, 1));
      check("out_valid", res_if.res_valid, 1);
      check("out_data", res_if.res_data, ones);
      check("out_row", res_if.res_row, r);
      check("out_last", res_if.res_last, (r == NR - 1));
      check("out_en", dp_en, 0);
      stall = (stall_max > 0) ? $urandom_range(1, stall_max) : 0;
      res_if.res_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        y = 1'($urandom_range(0, 1));
        step(); cyc++;
        check("stall_valid", res_if.res_valid, 1);
        check("stall_data", res_if.res_data, ones);
        check("stall_row", res_if.res_row, r);
        check("stall_sel", row_sel, r);
        check("stall_en", dp_en, 0);
        check("stall_nrst", dp_nrst, 1);
      end
      res_if.res_ready = 1'b1;
      step(); cyc++;
      res_if.res_ready = 1'b0;
    end
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", res_if.res_valid, 0);
    if (stall_max == 0) check("pass_cycles", cyc, NR * (W + WU + 2) + 1);
    if (chain) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end else begin
      step();
      check("done_clear", done, 0);
      for (int i = 0; i < 3; i++) begin
        step();
        check("idle_stay", busy, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0;
    start = 1'b0;
    y = 1'b0;
    res_if.res_ready = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_nrst", dp_nrst, 0);
    check("rst_valid", res_if.res_valid, 0);
    check("rst_done", done, 0);
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
    step();
    check("idle_nrst", dp_nrst, 1);
    check("idle_sel", row_sel, 0);

    run_pass(1, 0, 1'b1, 1'b0, 1'b0);
    run_pass(2, 0, 1'b1, 1'b0, 1'b0);
    run_pass(3, 0, 1'b1, 1'b0, 1'b1);
    run_pass(0, 10, 1'b1, 1'b1, 1'b0);
    check("chain_clear", dp_nrst, 0);
    check("chain_row", row_sel, 0);
    run_pass(0, 3, 1'b0, 1'b0, 1'b0);
    run_pass(4, 0, 1'b1, 1'b0, 1'b0);

    res_if.res_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2 * (W + WU + 2) + 1 + WU + 5; i++) begin
      y = 1'($urandom_range(0, 1));
      step();
    end
    check("pre_rst_en", dp_en, 1);
    check("pre_rst_row", row_sel, 2);
    #3;
    nRST = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_nrst", dp_nrst, 0);
    check("arst_en", dp_en, 0);
    check("arst_sel", row_sel, 0);
    check("arst_valid", res_if.res_valid, 0);
    check("arst_data", res_if.res_data, 0);
    check("arst_row", res_if.res_row, 0);
    check("arst_last", res_if.res_last, 0);
    check("arst_done", done, 0);
    res_if.res_ready = 1'b0;
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
      check("post_rst_nrst", dp_nrst, 1);
    end
    run_pass(0, 2, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
